// File: rtl/uart_cmd_controller_if.sv
// Request/response bundle between the command controller, the UART receiver/transmitter
// and the sensor interface. The controller takes the master side.
interface uart_cmd_controller_if #(
  parameter int ADDR_W = 5
);
  logic [15:0]       rx_data;
  logic              rx_concluded;
  logic              sens_req;
  logic [7:0]        sens_cmd;
  logic [ADDR_W-1:0] sens_addr;
  logic              sens_done;
  logic              sens_error;
  logic [7:0]        sens_data;
  logic              tx_busy;
  logic              tx_start;
  logic [7:0]        tx_data;

  modport master (
    input  rx_data, rx_concluded, sens_done, sens_error, sens_data, tx_busy,
    output sens_req, sens_cmd, sens_addr, tx_start, tx_data
  );

  modport slave (
    output rx_data, rx_concluded, sens_done, sens_error, sens_data, tx_busy,
    input  sens_req, sens_cmd, sens_addr, tx_start, tx_data
  );
endinterface

// File: rtl/uart_cmd_controller.sv
// Sequences one UART request at a time: range check, sensor dispatch with timeout,
// then a two-byte (status, data) reply through the transmitter.
module uart_cmd_controller #(
  parameter int         ADDR_W  = 5,
  parameter logic [7:0] CMD_MAX = 8'h07,
  parameter int         TIMEOUT = 96
) (
  input  logic                  clk_9k6hz,
  input  logic                  rst_n,
  uart_cmd_controller_if.master bus,
  output logic                  busy,
  output logic [7:0]            drop_cnt
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [7:0] ST_OK      = 8'h00;
  localparam logic [7:0] ST_BAD_CMD = 8'hE1;
  localparam logic [7:0] ST_BAD_ADR = 8'hE2;
  localparam logic [7:0] ST_SENS    = 8'hE3;
  localparam logic [7:0] ST_TIMEOUT = 8'hE4;

  typedef enum logic [2:0] {
    IDLE, CHECK, REQ, WAIT, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO
  } state_t;

  state_t            state, state_d;
  logic              rx_prev;
  logic              rx_rise;
  logic [7:0]        cmd_q, cmd_d;
  logic [7:0]        addr_q, addr_d;
  logic [7:0]        status_q, status_d;
  logic [7:0]        data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              guard_q, guard_d;
  logic [7:0]        sens_cmd_q, sens_cmd_d;
  logic [ADDR_W-1:0] sens_addr_q, sens_addr_d;
  logic [7:0]        tx_last_q, tx_last_d;
  logic              sens_req_c;
  logic              tx_start_c;
  logic [7:0]        tx_byte_c;

  assign rx_rise = bus.rx_concluded & ~rx_prev;

  // tx_data shows the outgoing byte during the tx_start cycle and otherwise holds the last byte sent
  assign bus.sens_req  = sens_req_c;
  assign bus.sens_cmd  = sens_cmd_q;
  assign bus.sens_addr = sens_addr_q;
  assign bus.tx_start  = tx_start_c;
  assign bus.tx_data   = tx_start_c ? tx_byte_c : tx_last_q;
  assign busy          = (state != IDLE);

  always_ff @(posedge clk_9k6hz or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rx_prev     <= 1'b0;
      cmd_q       <= '0;
      addr_q      <= '0;
      status_q    <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      guard_q     <= 1'b0;
      sens_cmd_q  <= '0;
      sens_addr_q <= '0;
      tx_last_q   <= '0;
      drop_cnt    <= '0;
    end else begin
      state       <= state_d;
      rx_prev     <= bus.rx_concluded;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      status_q    <= status_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      guard_q     <= guard_d;
      sens_cmd_q  <= sens_cmd_d;
      sens_addr_q <= sens_addr_d;
      tx_last_q   <= tx_last_d;
      if (rx_rise && (state != IDLE) && (drop_cnt != 8'hFF))
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

  always_comb begin
    state_d     = state;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    status_d    = status_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    guard_d     = 1'b0;
    sens_cmd_d  = sens_cmd_q;
    sens_addr_d = sens_addr_q;
    tx_last_d   = tx_last_q;
    sens_req_c  = 1'b0;
    tx_start_c  = 1'b0;
    tx_byte_c   = status_q;

    case (state)
      IDLE: begin
        if (rx_rise) begin
          cmd_d   = bus.rx_data[7:0];
          addr_d  = bus.rx_data[15:8];
          state_d = CHECK;
        end
      end

      // A bad command is reported ahead of a bad address
      CHECK: begin
        if (cmd_q > CMD_MAX) begin
          status_d = ST_BAD_CMD;
          data_d   = 8'h00;
          state_d  = SEND_HI;
        end else if ((addr_q >> ADDR_W) != 8'h00) begin
          status_d = ST_BAD_ADR;
          data_d   = 8'h00;
          state_d  = SEND_HI;
        end else begin
          sens_cmd_d  = cmd_q;
          sens_addr_d = addr_q[ADDR_W-1:0];
          state_d     = REQ;
        end
      end

      REQ: begin
        sens_req_c = 1'b1;
        cnt_d      = '0;
        state_d    = WAIT;
      end

      // A completion arriving on the final count still counts as a completion
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.sens_done) begin
          status_d = bus.sens_error ? ST_SENS : ST_OK;
          data_d   = bus.sens_error ? 8'h00 : bus.sens_data;
          state_d  = SEND_HI;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          status_d = ST_TIMEOUT;
          data_d   = 8'h00;
          state_d  = SEND_HI;
        end
      end

      SEND_HI: begin
        if (!bus.tx_busy) begin
          tx_start_c = 1'b1;
          tx_byte_c  = status_q;
          tx_last_d  = status_q;
          guard_d    = 1'b1;
          state_d    = WAIT_HI;
        end
      end

      // The guard covers the cycle before the transmitter raises tx_busy
      WAIT_HI: begin
        if (!guard_q && !bus.tx_busy)
          state_d = SEND_LO;
      end

      SEND_LO: begin
        if (!bus.tx_busy) begin
          tx_start_c = 1'b1;
          tx_byte_c  = data_q;
          tx_last_d  = data_q;
          guard_d    = 1'b1;
          state_d    = WAIT_LO;
        end
      end

      WAIT_LO: begin
        if (!guard_q && !bus.tx_busy)
          state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/uart_cmd_controller.md
Name: uart_cmd_controller

Overview:
- Command sequencer between the UART receiver, the sensor interface and the UART transmitter.
- Accepts each 2-byte request word from the receiver, range-checks the command and address, and dispatches a valid request to the sensor interface with a timeout.
- Returns a 2-byte response (status, then data) through the transmitter.
- Handles one transaction at a time. Requests that arrive while busy are dropped and counted.

Parameters:
- ADDR_W, 5, sensor address width; valid addresses are 0 .. 2^ADDR_W-1.
- CMD_MAX, 8'h07, highest legal command code; commands 0 .. CMD_MAX are legal.
- TIMEOUT, 96, clock cycles allowed between sens_req and sens_done (about 10 ms at 9600 Hz).

Ports:
- clk_9k6hz  in  1  system clock (9600 Hz bit clock).
- rst_n  in  1  asynchronous, active-low reset.
- rx_data  in  16  request word from the receiver: [7:0] = command byte, [15:8] = address byte.
- rx_concluded  in  1  level from the receiver; high while a complete 2-byte word is valid.
- sens_req  out  1  one-cycle request pulse to the sensor interface.
- sens_cmd  out  8  latched command; stable from sens_req until the transaction ends.
- sens_addr  out  ADDR_W  latched address; stable from sens_req until the transaction ends.
- sens_done  in  1  one-cycle completion pulse from the sensor interface.
- sens_error  in  1  sensor fault flag; sampled only when sens_done=1.
- sens_data  in  8  sensor result; sampled only when sens_done=1.
- tx_busy  in  1  transmitter busy; goes high the cycle after tx_start and stays high through the stop bit.
- tx_start  out  1  one-cycle transmit pulse.
- tx_data  out  8  byte to transmit; valid with tx_start and held until the next tx_start.
- busy  out  1  high in every state except IDLE.
- drop_cnt  out  8  count of dropped requests; saturates at 8'hFF.

Behaviour:
- Reset (asynchronous, while rst_n=0):
  - state=IDLE.
  - All outputs 0: sens_req, sens_cmd, sens_addr, tx_start, tx_data, busy, drop_cnt.
  - Internal registers cleared: rx edge register, timeout counter, status/data registers.
  - Reset during any state aborts the transaction. No further sens_req or tx_start is issued.
- New-request detection: a new request is a rising edge of rx_concluded (registered copy was 0, current value is 1).
- Edge in IDLE:
  - Latch rx_data[7:0] as the command and rx_data[15:8] as the address byte.
  - Go to CHECK.
- Edge in any other state: the request is dropped and drop_cnt increments (saturating). The current transaction is not affected.
- Status codes:
  - 8'h00 OK
  - 8'hE1 bad command
  - 8'hE2 bad address
  - 8'hE3 sensor error
  - 8'hE4 timeout
- CHECK (1 cycle):
  - Command > CMD_MAX: status=E1, data=00, go to SEND_HI.
  - Otherwise, address byte bits [7:ADDR_W] not all zero: status=E2, data=00, go to SEND_HI.
  - Bad command takes priority over bad address.
  - Otherwise: drive sens_cmd and sens_addr, go to REQ.
- REQ (1 cycle): sens_req=1, clear the timeout counter, go to WAIT.
- WAIT:
  - The counter increments every cycle.
  - sens_done=1: capture status (E3 if sens_error=1, else 00) and data (sens_data if sens_error=0, else 00); go to SEND_HI.
  - Counter reaches TIMEOUT-1 with sens_done=0: status=E4, data=00, go to SEND_HI.
  - sens_done on the same cycle the counter reaches TIMEOUT-1: done wins.
  - sens_done outside WAIT is ignored.
- SEND_HI:
  - Stays here while tx_busy=1.
  - When tx_busy=0: tx_start=1 and tx_data=status for one cycle, set the guard flag, go to WAIT_HI.
- WAIT_HI:
  - The guard flag clears after the first cycle; tx_busy is ignored on that first cycle.
  - Once the guard is clear and tx_busy=0: go to SEND_LO.
- SEND_LO and WAIT_LO: same as SEND_HI and WAIT_HI, but send the data byte. WAIT_LO returns to IDLE.
- Latency:
  - Edge to sens_req: 2 cycles (CHECK, then REQ).
  - sens_done to first tx_start: 1 cycle after WAIT exits, provided tx_busy=0.
- Exactly one sens_req per accepted valid request and none for rejected ones. Exactly two tx_start pulses per accepted request, status byte first.

Test Plan:
- Valid request: rx_data=16'h0301 (cmd 01, addr 03), edge; sensor answers done with sens_data=8'h1A after 10 cycles -> sens_req 2 cycles after the edge; sens_cmd=01, sens_addr=03; tx bytes 00 then 1A; busy returns to 0.
- Illegal command: rx_data=16'h0009 -> no sens_req; tx bytes E1 then 00.
- Illegal address: rx_data=16'h2001 -> no sens_req; tx bytes E2 then 00. Bad command plus bad address, rx_data=16'h2009 -> E1.
- Timeout: valid request, sens_done never pulses -> tx bytes E4 then 00, first tx_start after TIMEOUT (96) cycles. Second run with sens_done exactly on cycle 96 -> status 00.
- Sensor error: sens_done with sens_error=1 and sens_data=8'h55 -> tx bytes E3 then 00. tx_busy held high for 20 cycles -> tx_start waits until tx_busy=0.
- Overrun and reset:
  - Three extra rx_concluded edges during WAIT -> drop_cnt=3; current transaction completes normally.
  - 300 drops -> drop_cnt=FF.
  - rst_n pulsed low in SEND_LO -> all outputs 0 immediately; no further tx_start.
